// File: rtl/boot_image_loader_pkg.sv
// rtl/boot_image_loader_pkg.sv - shared boot configuration and loader state encoding
//
// BOOT_IMAGE_WORDS : default number of 32-bit words copied out of boot ROM
// BOOT_RAM_BASE    : default instruction-RAM byte address of image word 0
// boot_state_e     : loader FSM state encoding
package RISCV_MCU_CONFIG;

    localparam int          BOOT_IMAGE_WORDS = 1024;
    localparam logic [31:0] BOOT_RAM_BASE    = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } boot_state_e;

endpackage

// File: rtl/boot_image_loader.sv
// rtl/boot_image_loader.sv - copies a boot image from ROM into instruction RAM, then enables fetch
//
// Ports:
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   start_i           : level request; sampled only in IDLE
//   rom_req_o/addr_o  : ROM read strobe and word address (address is 0 when not reading)
//   rom_rdata_i       : ROM data, valid the cycle after rom_req_o
//   ram_req_o/gnt_i   : RAM write request, held with stable address/data until granted
//   ram_addr_o        : RAM byte address (RAM_BASE + 4*word)
//   ram_wdata_o/we_o/be_o : write data, write enable, byte enables (all 0 outside WRITE)
//   busy_o            : copy in progress
//   done_o            : copy complete (terminal until reset)
//   fetch_enable_o    : releases the core once the image is in RAM
module boot_image_loader
    import RISCV_MCU_CONFIG::*;
#(
    parameter int          ROM_ADDR_WIDTH = 12,
    parameter int          IMAGE_WORDS    = BOOT_IMAGE_WORDS,
    parameter logic [31:0] RAM_BASE       = BOOT_RAM_BASE,
    parameter int          INSTR_RAM_SIZE = 32768
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    output logic                      rom_req_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [31:0]               rom_rdata_i,
    output logic                      ram_req_o,
    input  logic                      ram_gnt_i,
    output logic [31:0]               ram_addr_o,
    output logic [31:0]               ram_wdata_o,
    output logic                      ram_we_o,
    output logic [3:0]                ram_be_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fetch_enable_o
);

    // Counter just wide enough for IMAGE_WORDS-1; a one-word image still needs one bit.
    localparam int              CNT_W    = (IMAGE_WORDS > 1) ? $clog2(IMAGE_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMAGE_WORDS - 1);

    localparam longint ROM_WORDS = longint'(1) << ROM_ADDR_WIDTH;
    localparam longint RAM_WORDS = longint'(INSTR_RAM_SIZE) / 64'sd4;

    // The image must fit both the ROM address space and the instruction RAM.
    if (longint'(IMAGE_WORDS) < 64'sd1 ||
        longint'(IMAGE_WORDS) > ROM_WORDS ||
        longint'(IMAGE_WORDS) > RAM_WORDS) begin : g_bad_cfg
        $error("boot_image_loader: IMAGE_WORDS out of range for ROM/RAM size");
    end

    boot_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      wdata_q, wdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wdata_d        = wdata_q;
        rom_req_o      = 1'b0;
        rom_addr_o     = '0;
        ram_req_o      = 1'b0;
        ram_addr_o     = '0;
        ram_wdata_o    = '0;
        ram_we_o       = 1'b0;
        ram_be_o       = 4'h0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        fetch_enable_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                busy_o     = 1'b1;
                rom_req_o  = 1'b1;
                rom_addr_o = ROM_ADDR_WIDTH'(cnt_q);
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                // ROM answers one cycle after the strobe, so the data lands here.
                busy_o  = 1'b1;
                wdata_d = rom_rdata_i;
                state_d = WRITE;
            end
            WRITE: begin
                // Everything below is a pure function of held flops, so the
                // request stays stable for as many cycles as the grant takes.
                busy_o      = 1'b1;
                ram_req_o   = 1'b1;
                ram_we_o    = 1'b1;
                ram_be_o    = 4'hF;
                ram_addr_o  = RAM_BASE + (32'(cnt_q) << 2);
                ram_wdata_o = wdata_q;
                if (ram_gnt_i) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                done_o         = 1'b1;
                fetch_enable_o = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_image_loader.sv
// tb/tb_boot_image_loader.sv - scoreboard bench for boot_image_loader (4-word, 1-word, 4096-word builds)
module tb_boot_image_loader;

    localparam logic [31:0] BASE_B = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: 4 words at base 0; index 1: 1 word at BASE_B; index 2: 4096 words at base 0.
    logic        rst_n     [3];
    logic        start     [3];
    logic        gnt       [3];
    logic        rom_req   [3];
    logic [11:0] rom_addr  [3];
    logic [31:0] rom_rdata [3];
    logic        ram_req   [3];
    logic [31:0] ram_addr  [3];
    logic [31:0] ram_wdata [3];
    logic        ram_we    [3];
    logic [3:0]  ram_be    [3];
    logic        busy      [3];
    logic        done      [3];
    logic        fetch     [3];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    boot_image_loader #(.ROM_ADDR_WIDTH(12), .IMAGE_WORDS(4), .RAM_BASE(32'h0), .INSTR_RAM_SIZE(32768)) u_dut4 (
        .clk(clk), .rst_n(rst_n[0]), .start_i(start[0]),
        .rom_req_o(rom_req[0]), .rom_addr_o(rom_addr[0]), .rom_rdata_i(rom_rdata[0]),
        .ram_req_o(ram_req[0]), .ram_gnt_i(gnt[0]), .ram_addr_o(ram_addr[0]),
        .ram_wdata_o(ram_wdata[0]), .ram_we_o(ram_we[0]), .ram_be_o(ram_be[0]),
        .busy_o(busy[0]), .done_o(done[0]), .fetch_enable_o(fetch[0]));

    boot_image_loader #(.ROM_ADDR_WIDTH(12), .IMAGE_WORDS(1), .RAM_BASE(BASE_B), .INSTR_RAM_SIZE(32768)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .start_i(start[1]),
        .rom_req_o(rom_req[1]), .rom_addr_o(rom_addr[1]), .rom_rdata_i(rom_rdata[1]),
        .ram_req_o(ram_req[1]), .ram_gnt_i(gnt[1]), .ram_addr_o(ram_addr[1]),
        .ram_wdata_o(ram_wdata[1]), .ram_we_o(ram_we[1]), .ram_be_o(ram_be[1]),
        .busy_o(busy[1]), .done_o(done[1]), .fetch_enable_o(fetch[1]));

    boot_image_loader #(.ROM_ADDR_WIDTH(12), .IMAGE_WORDS(4096), .RAM_BASE(32'h0), .INSTR_RAM_SIZE(32768)) u_dut4k (
        .clk(clk), .rst_n(rst_n[2]), .start_i(start[2]),
        .rom_req_o(rom_req[2]), .rom_addr_o(rom_addr[2]), .rom_rdata_i(rom_rdata[2]),
        .ram_req_o(ram_req[2]), .ram_gnt_i(gnt[2]), .ram_addr_o(ram_addr[2]),
        .ram_wdata_o(ram_wdata[2]), .ram_we_o(ram_we[2]), .ram_be_o(ram_be[2]),
        .busy_o(busy[2]), .done_o(done[2]), .fetch_enable_o(fetch[2]));

    // ROM model: word i holds 32'hA0+i, returned one cycle after the strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rom_rdata[i] <= rom_req[i] ? (32'hA0 + {20'h0, rom_addr[i]}) : 32'hDEAD_BEEF;
        end
    end

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? BASE_B : 32'h0;
    endfunction

    function automatic bit outputs_zero(input int d);
        return {rom_req[d], rom_addr[d], ram_req[d], ram_addr[d], ram_wdata[d], ram_we[d],
                ram_be[d], busy[d], done[d], fetch[d]} == '0;
    endfunction

    task automatic pulse_reset(input int d);
        @(negedge clk);
        rst_n[d] = 1'b0;
        start[d] = 1'b0;
        gnt[d]   = 1'b0;
        @(negedge clk);
        rst_n[d] = 1'b1;
        @(negedge clk);
    endtask

    // Runs one copy on DUT d with the scoreboard, then watches 'tail' cycles of DONE.
    task automatic drive_copy(input int d, input int n, input int stall_word, input int stall_n,
                              input bit drop_start, input bit spurious, input int tail,
                              output int done_cyc, output int writes, output int stall_cycles,
                              output logic [31:0] last_addr);
        wr_t         e;
        logic [31:0] stall_addr, ref_a, ref_d;
        bit          have_ref = 1'b0;
        int          stalled  = 0;
        int          cyc      = 0;
        int          post     = 0;
        int          limit;
        done_cyc     = 0;
        writes       = 0;
        stall_cycles = 0;
        last_addr    = '0;
        ref_a        = '0;
        ref_d        = '0;
        limit        = n * 3 + stall_n + 20;
        stall_addr   = base_of(d) + 32'(stall_word) * 4;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            e.addr = base_of(d) + 32'(i) * 4;
            e.data = 32'hA0 + 32'(i);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start[d] = 1'b1;
        gnt[d]   = spurious;
        while ((done_cyc == 0 && cyc < limit) || (done_cyc != 0 && post < tail)) begin
            @(negedge clk);
            cyc++;
            if (drop_start) start[d] = 1'b0;
            checks++;
            if (rom_req[d] && ram_req[d]) begin
                errors++;
                $display("FAIL req_overlap dut%0d cyc %0d: rom_req=%0b ram_req=%0b, required not both 1",
                         d, cyc, rom_req[d], ram_req[d]);
            end
            if (done_cyc == 0 && done[d] === 1'b1) done_cyc = cyc;
            checks++;
            if (done_cyc == 0) begin
                if (busy[d] !== 1'b1 || fetch[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_copy dut%0d cyc %0d: busy=%0b fetch=%0b, required busy=1 fetch=0",
                             d, cyc, busy[d], fetch[d]);
                end
            end else begin
                post++;
                if (busy[d] !== 1'b0 || fetch[d] !== 1'b1 || done[d] !== 1'b1 ||
                    rom_req[d] !== 1'b0 || ram_req[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL done_state dut%0d cyc %0d: busy=%0b fetch=%0b done=%0b rom_req=%0b ram_req=%0b, required 0 1 1 0 0",
                             d, cyc, busy[d], fetch[d], done[d], rom_req[d], ram_req[d]);
                end
            end
            checks++;
            if (!ram_req[d] && {ram_addr[d], ram_wdata[d], ram_we[d], ram_be[d]} !== '0) begin
                errors++;
                $display("FAIL ram_idle_zero dut%0d cyc %0d: addr=%h wdata=%h we=%0b be=%h, required all 0",
                         d, cyc, ram_addr[d], ram_wdata[d], ram_we[d], ram_be[d]);
            end
            checks++;
            if (!rom_req[d] && rom_addr[d] !== 12'h0) begin
                errors++;
                $display("FAIL rom_idle_zero dut%0d cyc %0d: rom_addr=%h, required 0", d, cyc, rom_addr[d]);
            end
            if (ram_req[d]) begin
                if (ram_addr[d] == stall_addr && stalled < stall_n) begin
                    gnt[d] = 1'b0;
                    stalled++;
                end else begin
                    gnt[d] = 1'b1;
                end
                if (ram_addr[d] == stall_addr) begin
                    stall_cycles++;
                    if (!have_ref) begin
                        ref_a    = ram_addr[d];
                        ref_d    = ram_wdata[d];
                        have_ref = 1'b1;
                    end else begin
                        checks++;
                        if (ram_addr[d] !== ref_a || ram_wdata[d] !== ref_d) begin
                            errors++;
                            $display("FAIL hold_stable dut%0d cyc %0d: addr=%h wdata=%h, required %h %h",
                                     d, cyc, ram_addr[d], ram_wdata[d], ref_a, ref_d);
                        end
                    end
                end
                if (gnt[d]) begin
                    writes++;
                    last_addr = ram_addr[d];
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_write dut%0d cyc %0d: addr=%h data=%h, required no write",
                                 d, cyc, ram_addr[d], ram_wdata[d]);
                    end else begin
                        e = exp_q.pop_front();
                        if (ram_addr[d] !== e.addr || ram_wdata[d] !== e.data ||
                            ram_we[d] !== 1'b1 || ram_be[d] !== 4'hF) begin
                            errors++;
                            $display("FAIL write dut%0d cyc %0d: addr=%h data=%h we=%0b be=%h, required %h %h 1 f",
                                     d, cyc, ram_addr[d], ram_wdata[d], ram_we[d], ram_be[d], e.addr, e.data);
                        end
                    end
                end
            end else begin
                gnt[d] = spurious;
            end
        end
        checks++;
        if (done_cyc == 0) begin
            errors++;
            $display("FAIL done_timeout dut%0d: done_o not seen in %0d cycles, required done", d, limit);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes dut%0d: %0d writes outstanding, required 0", d, exp_q.size());
        end
    endtask

    task automatic test_reset();
        // start and grant are asserted throughout reset: nothing may move.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (!outputs_zero(d)) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: busy=%0b done=%0b rom_req=%0b ram_req=%0b, required all 0",
                         d, busy[d], done[d], rom_req[d], ram_req[d]);
            end
        end
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0;
            gnt[d]   = 1'b0;
            rst_n[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (!outputs_zero(d)) begin
                errors++;
                $display("FAIL idle_no_start dut%0d: busy=%0b rom_req=%0b, required idle", d, busy[d], rom_req[d]);
            end
        end
    endtask

    task automatic test_basic4();
        int dc, wr, sc;
        logic [31:0] la;
        pulse_reset(0);
        drive_copy(0, 4, -1, 0, 1'b0, 1'b1, 5, dc, wr, sc, la);
        checks++;
        if (dc != 13) begin
            errors++;
            $display("FAIL basic4_done_cycle: %0d, required 13", dc);
        end
        checks++;
        if (wr != 4 || la !== 32'hC) begin
            errors++;
            $display("FAIL basic4_writes: count=%0d last=%h, required 4 0000000c", wr, la);
        end
    endtask

    task automatic test_stall();
        int dc, wr, sc;
        logic [31:0] la;
        pulse_reset(0);
        drive_copy(0, 4, 2, 5, 1'b0, 1'b0, 3, dc, wr, sc, la);
        checks++;
        if (sc != 6) begin
            errors++;
            $display("FAIL stall_write_cycles: %0d, required 6", sc);
        end
        checks++;
        if (dc != 18 || wr != 4) begin
            errors++;
            $display("FAIL stall_done: cycle=%0d writes=%0d, required 18 4", dc, wr);
        end
    endtask

    task automatic test_single();
        int dc, wr, sc;
        logic [31:0] la;
        drive_copy(1, 1, -1, 0, 1'b0, 1'b1, 20, dc, wr, sc, la);
        checks++;
        if (dc != 4 || wr != 1 || la !== BASE_B) begin
            errors++;
            $display("FAIL single_word: done_cycle=%0d writes=%0d addr=%h, required 4 1 %h", dc, wr, la, BASE_B);
        end
    endtask

    task automatic test_reset_midcopy();
        int dc, wr, sc, pre;
        logic [31:0] la;
        pre = 0;
        pulse_reset(0);
        @(negedge clk);
        start[0] = 1'b1;
        gnt[0]   = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (ram_req[0]) pre++;
        end
        checks++;
        if (pre != 2 || rom_req[0] !== 1'b1 || rom_addr[0] !== 12'd2) begin
            errors++;
            $display("FAIL midcopy_position: writes=%0d rom_req=%0b rom_addr=%0d, required 2 1 2",
                     pre, rom_req[0], rom_addr[0]);
        end
        #2;
        rst_n[0] = 1'b0;
        start[0] = 1'b0;
        #1;
        checks++;
        if (!outputs_zero(0)) begin
            errors++;
            $display("FAIL async_abort: busy=%0b rom_req=%0b rom_addr=%0d done=%0b, required all 0",
                     busy[0], rom_req[0], rom_addr[0], done[0]);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (!outputs_zero(0)) begin
            errors++;
            $display("FAIL no_restart_without_start: busy=%0b rom_req=%0b, required idle", busy[0], rom_req[0]);
        end
        drive_copy(0, 4, -1, 0, 1'b0, 1'b1, 3, dc, wr, sc, la);
        checks++;
        if (dc != 13 || wr != 4) begin
            errors++;
            $display("FAIL restart_copy: done_cycle=%0d writes=%0d, required 13 4", dc, wr);
        end
    endtask

    task automatic test_start_drop();
        int dc, wr, sc;
        logic [31:0] la;
        pulse_reset(0);
        drive_copy(0, 4, -1, 0, 1'b1, 1'b1, 10, dc, wr, sc, la);
        checks++;
        if (dc != 13 || wr != 4) begin
            errors++;
            $display("FAIL start_drop: done_cycle=%0d writes=%0d, required 13 4", dc, wr);
        end
    endtask

    task automatic test_full();
        int dc, wr, sc;
        logic [31:0] la;
        drive_copy(2, 4096, -1, 0, 1'b0, 1'b1, 100, dc, wr, sc, la);
        checks++;
        if (la !== 32'h3FFC || wr != 4096) begin
            errors++;
            $display("FAIL full_last_write: addr=%h writes=%0d, required 00003ffc 4096", la, wr);
        end
        checks++;
        if (dc != 12289) begin
            errors++;
            $display("FAIL full_done_cycle: %0d, required 12289", dc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            start[d] = 1'b1;
            gnt[d]   = 1'b1;
        end
        test_reset();
        test_basic4();
        test_stall();
        test_single();
        test_reset_midcopy();
        test_start_drop();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
